alu_rr_scheduler: RTL and testbench
===================================

# alu_rr_scheduler

Round-robin issue scheduler that shares one `int_alu` instance among `NUM_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and registers the granted operation into an issue stage that drives the ALU. It captures the ALU result into a response stage and returns it, tagged with the requester index, over a single valid/ready response port. Full throughput is one operation per cycle, with backpressure from the response consumer.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index. Derived; do not override.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester accept; at most one bit is high per cycle.
- `req_op_a`, input, `NUM_REQ*64`: operand A; requester i occupies bits [64i+63:64i].
- `req_op_b`, input, `NUM_REQ*64`: operand B, packed the same way.
- `req_opcode`, input, `NUM_REQ*5`: opcode; requester i occupies bits [5i+4:5i].
- `alu_op_a`, output, 64: to the ALU; driven from the issue register.
- `alu_op_b`, output, 64: to the ALU; driven from the issue register.
- `alu_opcode`, output, 5: to the ALU; driven from the issue register.
- `alu_result`, input, 64: combinational result from the ALU.
- `alu_valid`, input, 1: ALU result valid; when low, the issue stage stalls.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer accept.
- `rsp_result`, output, 64: returned result.
- `rsp_id`, output, `ID_W`: index of the requester that issued the operation.
- `rsp_err`, output, 1: illegal-opcode flag (see Configuration).
- `busy`, output, 1: high when either the issue stage or the response stage holds a valid operation.

## Operation
- Two register stages: issue stage (`iss_vld`, operands, opcode, id) and response stage (`rsp_vld`, result, id, err).
- Response advance: `rsp_adv = !rsp_vld | rsp_ready`.
- Issue advance: `iss_adv = iss_vld & alu_valid & rsp_adv`. On `iss_adv`, the response stage loads `alu_result`, the issue id and the err flag.
- Issue stage can accept when `!iss_vld | iss_adv`.
- Arbitration: round-robin over `req_valid`, starting search at pointer `rr_ptr`.
  - The winner w gets `req_ready[w]=1` only when the issue stage can accept.
  - `req_ready` is combinational; it never depends on `req_ready` itself.
- On a handshake (`req_valid[w] & req_ready[w]`):
  - The issue stage loads requester w's operands and opcode and sets id=w.
  - `rr_ptr` becomes `(w+1) mod NUM_REQ`.
  - With no handshake, `rr_ptr` holds.
- Requesters hold valid and payload stable until ready. The scheduler does not need to tolerate payload change while valid is high.
- Response stage clears when `rsp_valid & rsp_ready` and no new load occurs in the same cycle. A simultaneous drain and load keeps `rsp_vld=1` with the new data.
- Arithmetic is performed entirely by the ALU. The scheduler does not modify operands or the result.

## Timing
- Reset values, one edge with `rst_n=0`:
  - `iss_vld=0`, `rsp_vld=0`, `rr_ptr=0`.
  - `req_ready=0`, `rsp_valid=0`, `busy=0`.
  - `rsp_result=0`, `rsp_id=0`, `rsp_err=0`.
  - `alu_op_a`, `alu_op_b` and `alu_opcode` = 0.
- Reset mid-operation: in-flight issue and response contents are discarded. No response is produced for them.
- Latency: request accepted at edge E0 → ALU inputs valid in cycle E0..E1 → `rsp_valid=1` after edge E1, assuming `alu_valid=1` and the response stage free.
- Throughput: one accept per cycle while `rsp_ready=1` and `alu_valid=1`.
- Backpressure when `rsp_ready=0`:
  - With `rsp_vld=1`: the issue stage holds.
  - With both stages full: `req_ready=0`.
  - A third op is never lost.
- `alu_valid=0` with `iss_vld=1`: the issue stage holds; the response stage may still drain.
- Single requester: that requester is granted every eligible cycle regardless of `rr_ptr`.
- Pointer wrap: a grant to index `NUM_REQ-1` sets `rr_ptr=0`.

## Configuration
- Controlled by macro `ALU_SCHED_ILLEGAL_CHK_EN`.
- Defined: the issue stage computes err = (`opcode[2:0]==3'b111`).
  - `rsp_err` returns this flag with the response.
  - `rsp_result` is forced to 0 when err=1, in place of the ALU's `64'hDEAD_BEEF_DEAD_BEEF`.
- Undefined: `rsp_err` is tied to 0, and `rsp_result` passes `alu_result` unmodified for every opcode.

## Test plan
- Single op: req0 sends a=5, b=3, opcode=0 with `rsp_ready=1` → `req_ready[0]=1` in the same cycle; after 2 edges, `rsp_valid=1`, `rsp_result=8`, `rsp_id=0`.
- Round-robin: all 4 requesters are valid continuously, each with a distinct opcode, starting at `rr_ptr=0` → `rsp_id` sequence 0,1,2,3,0,1, with one response per cycle.
- Backpressure: 3 back-to-back ops from req2 with `rsp_ready=0` for 5 cycles:
  - Exactly 2 are accepted, then `req_ready=0` and `busy=1`.
  - After `rsp_ready=1`, all 3 results return in order with no loss or duplication.
- Stall: `alu_valid=0` for 3 cycles with one op in the issue stage → no response; the response appears 1 cycle after `alu_valid` returns high.
- Illegal opcode 3'b111:
  - Macro defined → `rsp_err=1`, `rsp_result=0`.
  - Macro undefined → `rsp_err=0`, `rsp_result=64'hDEAD_BEEF_DEAD_BEEF`.
- Reset mid-flight: `rst_n=0` for one edge with both stages full → `rsp_valid=0`, `busy=0`, `rr_ptr=0`; the next op returns normally.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin issue of NUM_REQ requesters onto one shared ALU through a registered issue
// stage and a registered response stage. Optional illegal-opcode check: ALU_SCHED_ILLEGAL_CHK_EN.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_op_a,
    input  logic [NUM_REQ*64-1:0] req_op_b,
    input  logic [NUM_REQ*5-1:0]  req_opcode,
    output logic [63:0]           alu_op_a,
    output logic [63:0]           alu_op_b,
    output logic [4:0]            alu_opcode,
    input  logic [63:0]           alu_result,
    input  logic                  alu_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err,
    output logic                  busy
);

    logic            iss_vld_reg;
    logic [63:0]     iss_op_a_reg;
    logic [63:0]     iss_op_b_reg;
    logic [4:0]      iss_opcode_reg;
    logic [ID_W-1:0] iss_id_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic            rsp_vld_reg;
    logic [63:0]     rsp_result_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic            rsp_err_reg;

    logic            rsp_adv;
    logic            iss_adv;
    logic            iss_accept;
    logic            iss_err;
    logic            handshake;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] rr_ptr_next;
    logic [63:0]     rsp_result_next;

    logic [ID_W-1:0]    cand_idx   [NUM_REQ];
    logic [NUM_REQ-1:0] cand_vld;
    logic [63:0]        op_a_arr   [NUM_REQ];
    logic [63:0]        op_b_arr   [NUM_REQ];
    logic [4:0]         opcode_arr [NUM_REQ];

    assign rsp_adv    = !rsp_vld_reg || rsp_ready;
    assign iss_adv    = iss_vld_reg && alu_valid && rsp_adv;
    // Gating with rst_n keeps a handshake from being seen on an edge that discards it.
    assign iss_accept = rst_n && (!iss_vld_reg || iss_adv);
    assign handshake  = iss_accept && grant_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [ID_W:0] sum;
            // Candidate gi is the requester gi places after rr_ptr, wrapped modulo NUM_REQ.
            assign sum           = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ?
                                   ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
            assign cand_vld[gi]  = req_valid[cand_idx[gi]];
            assign op_a_arr[gi]   = req_op_a[64*gi +: 64];
            assign op_b_arr[gi]   = req_op_b[64*gi +: 64];
            assign opcode_arr[gi] = req_opcode[5*gi +: 5];
            assign req_ready[gi]  = handshake && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef ALU_SCHED_ILLEGAL_CHK_EN
    assign iss_err = (iss_opcode_reg[2:0] == 3'b111);
`else
    assign iss_err = 1'b0;
`endif

    assign rsp_result_next = iss_err ? 64'd0 : alu_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_vld_reg    <= 1'b0;
            iss_op_a_reg   <= '0;
            iss_op_b_reg   <= '0;
            iss_opcode_reg <= '0;
            iss_id_reg     <= '0;
            rr_ptr_reg     <= '0;
            rsp_vld_reg    <= 1'b0;
            rsp_result_reg <= '0;
            rsp_id_reg     <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            if (iss_adv) begin
                rsp_vld_reg    <= 1'b1;
                rsp_result_reg <= rsp_result_next;
                rsp_id_reg     <= iss_id_reg;
                rsp_err_reg    <= iss_err;
            end else if (rsp_ready) begin
                rsp_vld_reg    <= 1'b0;
            end

            if (handshake) begin
                iss_vld_reg    <= 1'b1;
                iss_op_a_reg   <= op_a_arr[grant_idx];
                iss_op_b_reg   <= op_b_arr[grant_idx];
                iss_opcode_reg <= opcode_arr[grant_idx];
                iss_id_reg     <= grant_idx;
                rr_ptr_reg     <= rr_ptr_next;
            end else if (iss_adv) begin
                iss_vld_reg    <= 1'b0;
            end
        end
    end

    assign alu_op_a   = iss_op_a_reg;
    assign alu_op_b   = iss_op_b_reg;
    assign alu_opcode = iss_opcode_reg;
    assign rsp_valid  = rsp_vld_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_err    = rsp_err_reg;
    assign busy       = iss_vld_reg || rsp_vld_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a behavioural ALU plus a stage-occupancy reference model,
// driven by directed scenarios followed by randomized traffic.
module tb_alu_rr_scheduler;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*64-1:0]  req_op_a;
    logic [N*64-1:0]  req_op_b;
    logic [N*5-1:0]   req_opcode;
    logic [63:0]      alu_op_a;
    logic [63:0]      alu_op_b;
    logic [4:0]       alu_opcode;
    logic [63:0]      alu_result;
    logic             alu_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_err;
    logic             busy;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  op;
    } op_t;

    op_t cur  [N];
    bit  pend [N];

    // Reference model: contents of the two stages and the next requester to favour.
    int  m_rr     = 0;
    bit  m_iss_v  = 1'b0;
    bit  m_rsp_v  = 1'b0;
    op_t m_iss;
    op_t m_rsp;
    int  m_iss_id = 0;
    int  m_rsp_id = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] op);
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[5:0];
            3'd6:    return a >> b[5:0];
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op_a, alu_op_b, alu_opcode);

    function automatic logic exp_err(input op_t o);
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
        return (o.op[2:0] == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] exp_res(input op_t o);
        if (exp_err(o)) return 64'd0;
        return alu_f(o.a, o.b, o.op);
    endfunction

    alu_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .req_opcode (req_opcode),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_valid  (alu_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic refill(input int i, input logic [4:0] op);
        cur[i].a  = {$urandom, $urandom};
        cur[i].b  = {$urandom, $urandom};
        cur[i].op = op;
        pend[i]   = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pend[i];
            req_op_a[64*i +: 64]    = cur[i].a;
            req_op_b[64*i +: 64]    = cur[i].b;
            req_opcode[5*i +: 5]    = cur[i].op;
        end
    endtask

    // Checks the current cycle against the model, advances the model, then crosses one edge.
    task automatic step();
        int         g;
        int         idx;
        logic [N-1:0] exp_rdy;
        bit         rsp_free;
        bit         adv;
        bit         acc_ok;
        #1;
        rsp_free = !m_rsp_v || rsp_ready;
        adv      = m_iss_v && alu_valid && rsp_free;
        acc_ok   = (rst_n == 1'b1) && (!m_iss_v || adv);
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (acc_ok && g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
        chk("busy", 64'(busy), 64'(m_iss_v || m_rsp_v));
        if (m_rsp_v) begin
            chk("rsp_result", rsp_result, exp_res(m_rsp));
            chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
            chk("rsp_err", 64'(rsp_err), 64'(exp_err(m_rsp)));
        end
        if (m_iss_v) begin
            chk("alu_op_a", alu_op_a, m_iss.a);
            chk("alu_op_b", alu_op_b, m_iss.b);
            chk("alu_opcode", 64'(alu_opcode), 64'(m_iss.op));
        end

        if (!rst_n) begin
            m_iss_v = 1'b0;
            m_rsp_v = 1'b0;
            m_rr    = 0;
        end else begin
            if (m_rsp_v && rsp_ready)
                $display("rsp id=%0d result=%h err=%b", rsp_id, rsp_result, rsp_err);
            if (adv) begin
                m_rsp    = m_iss;
                m_rsp_id = m_iss_id;
                m_rsp_v  = 1'b1;
            end else if (rsp_ready) begin
                m_rsp_v  = 1'b0;
            end
            if (acc_ok && g >= 0) begin
                m_iss    = cur[g];
                m_iss_id = g;
                m_iss_v  = 1'b1;
                m_rr     = (g + 1) % N;
                pend[g]  = 1'b0;
            end else if (adv) begin
                m_iss_v  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive();
            step();
        end
    endtask

    initial begin
        int n_sent;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            cur[i]  = '0;
        end
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        alu_valid = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // Reset state.
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_alu_op_a", alu_op_a, 64'd0);
        chk("rst_alu_op_b", alu_op_b, 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        step();
        rst_n = 1'b1;

        // Single op: 5 + 3 from requester 0.
        cur[0].a = 64'd5; cur[0].b = 64'd3; cur[0].op = 5'd0; pend[0] = 1'b1;
        drive(); step();
        drive(); step();
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_result", rsp_result, 64'd8);
        chk("single_id", 64'(rsp_id), 64'd0);
        idle(3);

        // Round-robin with all requesters continuously valid.
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) refill(i, 5'(i));
            drive(); step();
        end
        idle(4);

        // Backpressure: three back-to-back ops from requester 2.
        rsp_ready = 1'b0;
        n_sent = 0;
        for (int c = 0; c < 5; c++) begin
            if (!pend[2] && n_sent < 3) begin refill(2, 5'($urandom_range(0, 6))); n_sent++; end
            drive(); step();
        end
        chk("bp_ready", 64'(req_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (!pend[2] && n_sent < 3) begin refill(2, 5'($urandom_range(0, 6))); n_sent++; end
            drive(); step();
        end
        idle(2);

        // ALU stall with one op in the issue stage.
        alu_valid = 1'b0;
        refill(1, 5'd0);
        drive(); step();
        idle(3);
        alu_valid = 1'b1;
        idle(1);
        chk("stall_release", 64'(rsp_valid), 64'd1);
        idle(2);

        // Illegal opcode.
        refill(3, 5'b00111);
        drive(); step();
        drive(); step();
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
        chk("illegal_err", 64'(rsp_err), 64'd1);
        chk("illegal_result", rsp_result, 64'd0);
`else
        chk("illegal_err", 64'(rsp_err), 64'd0);
        chk("illegal_result", rsp_result, 64'hDEAD_BEEF_DEAD_BEEF);
`endif
        idle(2);

        // Reset with both stages full, then a normal op.
        rsp_ready = 1'b0;
        refill(0, 5'd1);
        refill(1, 5'd2);
        idle(3);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(1);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        chk("rstmid_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        refill(2, 5'd0);
        drive(); step();
        drive(); step();
        chk("rstmid_next_valid", 64'(rsp_valid), 64'd1);
        chk("rstmid_next_id", 64'(rsp_id), 64'd2);
        idle(2);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            alu_valid = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < 40) refill(i, 5'($urandom_range(0, 31)));
            if (c == 250) begin
                rst_n = 1'b0;
                for (int i = 0; i < N; i++) pend[i] = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            drive();
            step();
        end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        alu_valid = 1'b1;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
